// File: rtl/systolic_feeder.sv
// Upstream feeder for the 2x2 weight-stationary systolic array: latches weights, streams a
// locally buffered 2-row activation matrix with row skew, then drains with zero inputs.
module systolic_feeder #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MAX_COLS  = 4,
  parameter int unsigned DRAIN_CYC = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en_i,
  input  logic [$clog2(2*MAX_COLS)-1:0] wr_addr_i,
  input  logic [DATA_W-1:0]             wr_data_i,
  input  logic [DATA_W-1:0]             w_in1_i,
  input  logic [DATA_W-1:0]             w_in2_i,
  input  logic [DATA_W-1:0]             w_in3_i,
  input  logic [DATA_W-1:0]             w_in4_i,
  input  logic [2:0]                    num_cols_i,
  input  logic                          start_i,
  output logic                          load_weight_o,
  output logic [DATA_W-1:0]             weight1_o,
  output logic [DATA_W-1:0]             weight2_o,
  output logic [DATA_W-1:0]             weight3_o,
  output logic [DATA_W-1:0]             weight4_o,
  output logic                          valid_o,
  output logic [DATA_W-1:0]             a_in1_o,
  output logic [DATA_W-1:0]             a_in2_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          cfg_err_o
);

  localparam int unsigned Depth = 2 * MAX_COLS;
  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned ColW  = $clog2(MAX_COLS + 1);
  localparam int unsigned DrnW  = $clog2(DRAIN_CYC + 1);

  typedef enum logic [2:0] {StIdle, StLoad, StFeed, StDrain, StDone} state_e;

  state_e              state_q;
  logic [DATA_W-1:0]   buf_q [Depth];
  logic [ColW-1:0]     col_q;
  logic [ColW-1:0]     ncols_q;
  logic [DrnW-1:0]     drn_q;

  logic                load_q;
  logic                valid_q;
  logic                busy_q;
  logic                done_q;
  logic                cfg_err_q;
  logic [DATA_W-1:0]   w1_q, w2_q, w3_q, w4_q;
  logic [DATA_W-1:0]   a1_q, a2_q;

  logic                start_ok;
  logic                wr_ok;
  logic [ColW-1:0]     col_nxt;
  logic [AddrW-1:0]    rd0_addr;
  logic [AddrW-1:0]    rd1_addr;

  assign start_ok = (num_cols_i != 3'd0) && (32'(num_cols_i) <= MAX_COLS);
  assign wr_ok    = wr_en_i && ((state_q == StIdle) || (state_q == StDone)) &&
                    (32'(wr_addr_i) < Depth);

  // Addresses for the column presented after the current one; row 1 lags row 0 by one column.
  assign col_nxt  = col_q + ColW'(1);
  assign rd0_addr = AddrW'(col_nxt);
  assign rd1_addr = AddrW'(MAX_COLS) + AddrW'(col_q);

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(Depth); i++) begin
        buf_q[i] <= '0;
      end
    end else if (wr_ok) begin
      buf_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      col_q     <= '0;
      ncols_q   <= '0;
      drn_q     <= '0;
      load_q    <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      w1_q      <= '0;
      w2_q      <= '0;
      w3_q      <= '0;
      w4_q      <= '0;
      a1_q      <= '0;
      a2_q      <= '0;
    end else begin
      load_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start_i) begin
            if (start_ok) begin
              state_q <= StLoad;
              ncols_q <= ColW'(num_cols_i);
              w1_q    <= w_in1_i;
              w2_q    <= w_in2_i;
              w3_q    <= w_in3_i;
              w4_q    <= w_in4_i;
              load_q  <= 1'b1;
              busy_q  <= 1'b1;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        StLoad: begin
          state_q <= StFeed;
          col_q   <= '0;
          valid_q <= 1'b1;
          a1_q    <= buf_q[0];
          a2_q    <= '0;
        end
        StFeed: begin
          if (col_q == ncols_q) begin
            state_q <= StDrain;
            drn_q   <= DrnW'(1);
            a1_q    <= '0;
            a2_q    <= '0;
          end else begin
            col_q <= col_nxt;
            a1_q  <= (col_nxt < ncols_q) ? buf_q[rd0_addr] : '0;
            a2_q  <= buf_q[rd1_addr];
          end
        end
        StDrain: begin
          if (drn_q == DrnW'(DRAIN_CYC)) begin
            state_q <= StDone;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drn_q <= drn_q + DrnW'(1);
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign load_weight_o = load_q;
  assign weight1_o     = w1_q;
  assign weight2_o     = w2_q;
  assign weight3_o     = w3_q;
  assign weight4_o     = w4_q;
  assign valid_o       = valid_q;
  assign a_in1_o       = a1_q;
  assign a_in2_o       = a2_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign cfg_err_o     = cfg_err_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed and randomized bench for systolic_feeder; expected per-cycle output frames are built
// from a buffer/weight model and compared against the DUT every cycle of each run.
module tb_systolic_feeder;

  localparam int DW = 16;
  localparam int MC = 4;
  localparam int D  = 4;

  typedef struct packed {
    logic          lw;
    logic          vld;
    logic          bsy;
    logic          dn;
    logic          ce;
    logic [DW-1:0] a1;
    logic [DW-1:0] a2;
    logic [DW-1:0] w1;
    logic [DW-1:0] w2;
    logic [DW-1:0] w3;
    logic [DW-1:0] w4;
  } frame_t;

  logic          clk;
  logic          reset;
  logic          wr_en;
  logic [2:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] w_in1, w_in2, w_in3, w_in4;
  logic [2:0]    num_cols;
  logic          start;
  logic          load_weight;
  logic [DW-1:0] weight1, weight2, weight3, weight4;
  logic          valid;
  logic [DW-1:0] a_in1, a_in2;
  logic          busy;
  logic          done;
  logic          cfg_err;

  int            n_checks;
  int            n_fail;
  logic [DW-1:0] mem [2*MC];
  logic [DW-1:0] cur_w [4];

  systolic_feeder #(
    .DATA_W    (DW),
    .MAX_COLS  (MC),
    .DRAIN_CYC (D)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_en_i       (wr_en),
    .wr_addr_i     (wr_addr),
    .wr_data_i     (wr_data),
    .w_in1_i       (w_in1),
    .w_in2_i       (w_in2),
    .w_in3_i       (w_in3),
    .w_in4_i       (w_in4),
    .num_cols_i    (num_cols),
    .start_i       (start),
    .load_weight_o (load_weight),
    .weight1_o     (weight1),
    .weight2_o     (weight2),
    .weight3_o     (weight3),
    .weight4_o     (weight4),
    .valid_o       (valid),
    .a_in1_o       (a_in1),
    .a_in2_o       (a_in2),
    .busy_o        (busy),
    .done_o        (done),
    .cfg_err_o     (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic frame_t idle_frame();
    frame_t f;
    f    = '0;
    f.w1 = cur_w[0];
    f.w2 = cur_w[1];
    f.w3 = cur_w[2];
    f.w4 = cur_w[3];
    return f;
  endfunction

  task automatic check(input frame_t exp, input string tag);
    frame_t obs;
    obs.lw  = load_weight;
    obs.vld = valid;
    obs.bsy = busy;
    obs.dn  = done;
    obs.ce  = cfg_err;
    obs.a1  = a_in1;
    obs.a2  = a_in2;
    obs.w1  = weight1;
    obs.w2  = weight2;
    obs.w3  = weight3;
    obs.w4  = weight4;
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic write(input int addr, input logic [DW-1:0] data);
    wr_en   = 1'b1;
    wr_addr = 3'(addr);
    wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
    mem[addr] = data;
  endtask

  task automatic set_weights_random();
    w_in1 = DW'($urandom);
    w_in2 = DW'($urandom);
    w_in3 = DW'($urandom);
    w_in4 = DW'($urandom);
  endtask

  // One accepted run: the frame list holds the expected outputs for each cycle after start.
  task automatic run(input int n, input bit hold, input bit busy_wr, input bit wr99,
                     input string tag);
    frame_t q[$];
    frame_t f;
    if (wr99) begin
      wr_en   = 1'b1;
      wr_addr = 3'd0;
      wr_data = DW'(99);
      mem[0]  = DW'(99);
    end
    start    = 1'b1;
    num_cols = 3'(n);
    cur_w[0] = w_in1;
    cur_w[1] = w_in2;
    cur_w[2] = w_in3;
    cur_w[3] = w_in4;
    f     = idle_frame();
    f.lw  = 1'b1;
    f.bsy = 1'b1;
    q.push_back(f);
    for (int i = 0; i <= n + D; i++) begin
      f     = idle_frame();
      f.vld = 1'b1;
      f.bsy = 1'b1;
      f.a1  = (i < n) ? mem[i] : '0;
      f.a2  = (i >= 1 && i <= n) ? mem[MC + i - 1] : '0;
      q.push_back(f);
    end
    f    = idle_frame();
    f.dn = 1'b1;
    q.push_back(f);
    q.push_back(idle_frame());
    @(negedge clk);
    if (!hold) start = 1'b0;
    wr_en = 1'b0;
    check(q[0], $sformatf("%s t=0", tag));
    for (int i = 1; i < q.size(); i++) begin
      if (busy_wr && q[i-1].bsy) begin
        wr_en   = 1'b1;
        wr_addr = 3'($urandom_range(0, 7));
        wr_data = DW'($urandom);
      end
      @(negedge clk);
      wr_en = 1'b0;
      check(q[i], $sformatf("%s t=%0d", tag, i));
    end
  endtask

  task automatic illegal(input int n);
    frame_t f;
    set_weights_random();
    start    = 1'b1;
    num_cols = 3'(n);
    @(negedge clk);
    start = 1'b0;
    f     = idle_frame();
    f.ce  = 1'b1;
    check(f, $sformatf("cfg_err n=%0d", n));
    @(negedge clk);
    check(idle_frame(), $sformatf("after cfg_err n=%0d", n));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    w_in1    = '0;
    w_in2    = '0;
    w_in3    = '0;
    w_in4    = '0;
    num_cols = '0;
    start    = 1'b0;
    for (int i = 0; i < 2*MC; i++) mem[i] = '0;
    for (int i = 0; i < 4; i++) cur_w[i] = '0;

    @(negedge clk);
    @(negedge clk);
    check(idle_frame(), "reset");
    reset = 1'b1;
    @(negedge clk);
    check(idle_frame(), "idle after reset");

    // Canonical 2x2 run
    write(0, 16'd11);
    write(1, 16'd12);
    write(4, 16'd21);
    write(5, 16'd22);
    w_in1 = 16'd3;
    w_in2 = 16'd5;
    w_in3 = 16'd4;
    w_in4 = 16'd6;
    run(2, 1'b0, 1'b0, 1'b0, "canon");

    // Full width
    for (int i = 0; i < MC; i++) write(i, DW'(i + 1));
    for (int i = 0; i < MC; i++) write(MC + i, DW'(i + 5));
    set_weights_random();
    run(4, 1'b0, 1'b0, 1'b0, "n4");

    // Randomized runs
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 2*MC; i++) write(i, DW'($urandom));
      set_weights_random();
      run($urandom_range(1, MC), 1'b0, 1'b0, 1'b0, $sformatf("rand%0d", r));
    end

    // Writes while busy are dropped; a repeat run must stream the same data
    set_weights_random();
    run(3, 1'b0, 1'b1, 1'b0, "busywr");
    run(3, 1'b0, 1'b0, 1'b0, "repeat");

    // Write racing start is visible
    set_weights_random();
    run(2, 1'b0, 1'b0, 1'b1, "wr99");

    // Illegal configs then a legal run
    illegal(0);
    illegal(5);
    illegal($urandom_range(6, 7));
    set_weights_random();
    run(1, 1'b0, 1'b0, 1'b0, "post_illegal");

    // Start held high: back-to-back runs with one idle cycle in between
    set_weights_random();
    run(2, 1'b1, 1'b0, 1'b0, "hold1");
    set_weights_random();
    run(3, 1'b1, 1'b0, 1'b0, "hold2");
    start = 1'b0;
    @(negedge clk);
    check(idle_frame(), "hold released");

    // Reset during the second FEED cycle
    for (int i = 0; i < 2*MC; i++) write(i, DW'($urandom_range(1, 65535)));
    set_weights_random();
    start    = 1'b1;
    num_cols = 3'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2*MC; i++) mem[i] = '0;
    for (int i = 0; i < 4; i++) cur_w[i] = '0;
    check(idle_frame(), "midrun reset");
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check(idle_frame(), $sformatf("post reset idle %0d", i));
    end
    set_weights_random();
    run(2, 1'b0, 1'b0, 1'b0, "zeros");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
